// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: FSM state encoding and frame segment lengths in NEC units.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark
  } state_t;

  localparam logic [4:0] LEAD_MARK_U  = 5'd16;
  localparam logic [4:0] LEAD_SPACE_U = 5'd8;
  localparam logic [4:0] REP_SPACE_U  = 5'd4;
  localparam logic [4:0] BIT_MARK_U   = 5'd1;
  localparam logic [4:0] ZERO_SPACE_U = 5'd1;
  localparam logic [4:0] ONE_SPACE_U  = 5'd3;
  localparam logic [4:0] STOP_U       = 5'd1;

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running ~38 kHz carrier divider; iSYNC parks the phase at the start of the high half.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic CLK,
  input  logic NRST,
  input  logic iSYNC,
  output logic oCARRIER
);

  localparam int unsigned PhW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(CARRIER_HALF - 1);

  logic [PhW-1:0] r_phase;
  logic           r_carrier;

  always_ff @(posedge CLK) begin
    if (NRST || iSYNC) begin
      r_phase   <= '0;
      r_carrier <= 1'b1;
    end else if (r_phase == PhLast) begin
      r_phase   <= '0;
      r_carrier <= ~r_carrier;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign oCARRIER = r_carrier;

endmodule

// File: rtl/irda_nec_tx.sv
// NEC IR transmitter: serialises a 32-bit frame (LSB first) or a repeat frame onto a
// 38 kHz modulated IR LED output.
module irda_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYC     = 28125,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        iSTART,
  input  logic        iREPEAT,
  input  logic [31:0] iDATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oENV,
  output logic        oIRDA_TXD
);

  localparam int unsigned UnitW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam logic [UnitW-1:0] UnitLast = UnitW'(UNIT_CYC - 1);

  state_t            r_state, w_state_d;
  logic [UnitW-1:0]  r_unit_cnt, w_unit_cnt_d;
  logic [4:0]        r_units, w_units_d;
  logic [4:0]        r_bit_idx, w_bit_idx_d;
  logic [31:0]       r_shift, w_shift_d;
  logic              r_repeat, w_repeat_d;
  logic              r_busy, r_env, r_done;
  logic              w_busy_d, w_env_d, w_done_d;
  logic              w_unit_end, w_last_unit;
  logic              w_sync, w_carrier;

  assign w_unit_end  = (r_unit_cnt == UnitLast);
  assign w_last_unit = w_unit_end && (r_units == 5'd1);

  always_comb begin
    w_state_d    = r_state;
    w_unit_cnt_d = r_unit_cnt;
    w_units_d    = r_units;
    w_bit_idx_d  = r_bit_idx;
    w_shift_d    = r_shift;
    w_repeat_d   = r_repeat;
    w_done_d     = 1'b0;

    if (r_state == StIdle) begin
      if (iSTART) begin
        w_state_d    = StLeadMark;
        w_unit_cnt_d = '0;
        w_units_d    = LEAD_MARK_U;
        w_bit_idx_d  = '0;
        w_shift_d    = iDATA;
        w_repeat_d   = iREPEAT;
      end
    end else begin
      w_unit_cnt_d = w_unit_end ? '0 : r_unit_cnt + 1'b1;
      if (w_unit_end) w_units_d = r_units - 1'b1;
      if (w_last_unit) begin
        unique case (r_state)
          StLeadMark: begin
            w_state_d = StLeadSpace;
            w_units_d = r_repeat ? REP_SPACE_U : LEAD_SPACE_U;
          end
          StLeadSpace: begin
            w_state_d = r_repeat ? StStopMark : StBitMark;
            w_units_d = r_repeat ? STOP_U : BIT_MARK_U;
          end
          StBitMark: begin
            w_state_d = StBitSpace;
            w_units_d = r_shift[0] ? ONE_SPACE_U : ZERO_SPACE_U;
          end
          StBitSpace: begin
            if (r_bit_idx == 5'd31) begin
              w_state_d = StStopMark;
              w_units_d = STOP_U;
            end else begin
              w_state_d   = StBitMark;
              w_units_d   = BIT_MARK_U;
              w_bit_idx_d = r_bit_idx + 1'b1;
              w_shift_d   = {1'b0, r_shift[31:1]};
            end
          end
          StStopMark: begin
            w_state_d = StIdle;
            w_units_d = '0;
            w_done_d  = 1'b1;
          end
          default: w_state_d = StIdle;
        endcase
      end
    end
  end

  assign w_busy_d = (w_state_d != StIdle);
  assign w_env_d  = (w_state_d == StLeadMark) || (w_state_d == StBitMark) ||
                    (w_state_d == StStopMark);

  always_ff @(posedge CLK) begin
    if (NRST) begin
      r_state    <= StIdle;
      r_unit_cnt <= '0;
      r_units    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_repeat   <= 1'b0;
      r_busy     <= 1'b0;
      r_env      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_unit_cnt <= w_unit_cnt_d;
      r_units    <= w_units_d;
      r_bit_idx  <= w_bit_idx_d;
      r_shift    <= w_shift_d;
      r_repeat   <= w_repeat_d;
      r_busy     <= w_busy_d;
      r_env      <= w_env_d;
      r_done     <= w_done_d;
    end
  end

  // Hold the carrier parked high except while a mark continues, so each mark starts high.
  assign w_sync = ~(w_env_d & r_env);

  ir_carrier_gen #(
    .CARRIER_HALF (CARRIER_HALF)
  ) u_carrier (
    .CLK      (CLK),
    .NRST     (NRST),
    .iSYNC    (w_sync),
    .oCARRIER (w_carrier)
  );

  assign oBUSY     = r_busy;
  assign oDONE     = r_done;
  assign oENV      = r_env;
  assign oIRDA_TXD = r_env & w_carrier;

endmodule

// File: tb/tb_irda_nec_tx.sv
// Directed bench for irda_nec_tx with UNIT_CYC=10, CARRIER_HALF=2.
module tb_irda_nec_tx;

  localparam int unsigned Unit  = 10;
  localparam int unsigned Half  = 2;
  localparam int          Bound = 4000;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        start = 1'b0;
  logic        rep = 1'b0;
  logic [31:0] data = '0;
  logic        busy, done, env, txd;

  int n_vec = 0;
  int n_err = 0;

  logic env_log [0:Bound-1];
  logic txd_log [0:Bound-1];
  int   n_busy;
  int   n_done_busy;
  logic done_at_fall;
  logic first_busy;

  always #5 clk = ~clk;

  irda_nec_tx #(
    .UNIT_CYC     (Unit),
    .CARRIER_HALF (Half)
  ) dut (
    .CLK       (clk),
    .NRST      (nrst),
    .iSTART    (start),
    .iREPEAT   (rep),
    .iDATA     (data),
    .oBUSY     (busy),
    .oDONE     (done),
    .oENV      (env),
    .oIRDA_TXD (txd)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pulses iSTART and logs the frame until busy falls.
  // poke_at >= 0 re-pulses iSTART (with all-ones data) at that busy cycle.
  task automatic run_frame(input logic [31:0] d, input logic r, input int poke_at);
    start = 1'b1; data = d; rep = r;
    @(negedge clk);
    start = 1'b0;
    first_busy  = busy;
    n_busy      = 0;
    n_done_busy = 0;
    while (busy && n_busy < Bound) begin
      env_log[n_busy] = env;
      txd_log[n_busy] = txd;
      if (done) n_done_busy++;
      if (n_busy == poke_at) begin
        start = 1'b1; data = 32'hFFFF_FFFF; rep = 1'b0;
      end else begin
        start = 1'b0;
      end
      n_busy++;
      @(negedge clk);
    end
    start = 1'b0;
    if (n_busy >= Bound) check_eq("frame_timeout", 32'(n_busy), 32'(Bound - 1));
    done_at_fall = done;
  endtask

  function automatic logic [31:0] decode_env(input int len);
    int i = 0;
    int run;
    logic [31:0] v = '0;
    while (i < len && env_log[i]) i++;
    while (i < len && !env_log[i]) i++;
    for (int b = 0; b < 32; b++) begin
      while (i < len && env_log[i]) i++;
      run = 0;
      while (i < len && !env_log[i]) begin
        run++;
        i++;
      end
      v[b] = (run > 2 * Unit);
    end
    return v;
  endfunction

  initial begin
    int hi, lo, mism;
    logic exp_t;

    // 1. reset with iSTART held high
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_env", env, 1'b0);
    check_eq("rst_txd", txd, 1'b0);
    check_eq("rst_done", done, 1'b0);
    nrst = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);

    // 2. all-zero payload
    run_frame(32'h0000_0000, 1'b0, -1);
    check_eq("zero_len", 32'(n_busy), 32'd890);
    hi = 0;
    for (int i = 0; i < 160; i++) if (env_log[i]) hi++;
    check_eq("zero_lead_hi", 32'(hi), 32'd160);
    check_eq("zero_lead_end", env_log[160], 1'b0);
    check_eq("zero_done_fall", done_at_fall, 1'b1);
    check_eq("zero_done_early", 32'(n_done_busy), 32'd0);
    @(negedge clk);
    check_eq("zero_done_1cyc", done, 1'b0);

    // 3. all-ones and a real key code
    run_frame(32'hFFFF_FFFF, 1'b0, -1);
    check_eq("ones_len", 32'(n_busy), 32'd1530);
    check_eq("ones_decode", decode_env(n_busy), 32'hFFFF_FFFF);
    @(negedge clk);
    run_frame(32'hE718_FF00, 1'b0, -1);
    check_eq("key_len", 32'(n_busy), 32'd1210);
    check_eq("key_decode", decode_env(n_busy), 32'hE718_FF00);

    // 4. repeat frame; payload must be ignored
    @(negedge clk);
    run_frame(32'h1234_5678, 1'b1, -1);
    check_eq("rep_len", 32'(n_busy), 32'd210);
    hi = 0; lo = 0; mism = 0;
    for (int i = 0; i < 160; i++) if (env_log[i]) hi++;
    for (int i = 160; i < 200; i++) if (!env_log[i]) lo++;
    check_eq("rep_lead_hi", 32'(hi), 32'd160);
    check_eq("rep_space_lo", 32'(lo), 32'd40);
    hi = 0;
    for (int i = 200; i < 210; i++) if (env_log[i]) hi++;
    check_eq("rep_stop_hi", 32'(hi), 32'd10);
    for (int i = 0; i < 210; i++) begin
      if (i < 160)      exp_t = ((i / 2) % 2) == 0;
      else if (i < 200) exp_t = 1'b0;
      else              exp_t = (((i - 200) / 2) % 2) == 0;
      if (txd_log[i] !== exp_t) mism++;
    end
    check_eq("rep_txd_mism", 32'(mism), 32'd0);
    check_eq("rep_txd_2", txd_log[2], 1'b0);
    check_eq("rep_txd_201", txd_log[201], 1'b1);

    // 5. iSTART while busy ignored; iSTART in the done cycle accepted
    @(negedge clk);
    run_frame(32'h0000_0000, 1'b0, 100);
    check_eq("poke_len", 32'(n_busy), 32'd890);
    check_eq("poke_done", done_at_fall, 1'b1);
    run_frame(32'h0000_0000, 1'b0, -1);
    check_eq("b2b_first_busy", first_busy, 1'b1);
    check_eq("b2b_len", 32'(n_busy), 32'd890);

    // 6. reset during bit 12 space, then a clean frame
    @(negedge clk);
    start = 1'b1; data = 32'h0000_0000; rep = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (495) @(negedge clk);
    check_eq("mid_busy", busy, 1'b1);
    check_eq("mid_env", env, 1'b0);
    nrst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_env", env, 1'b0);
    check_eq("abort_txd", txd, 1'b0);
    check_eq("abort_done", done, 1'b0);
    nrst = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) hi++;
    end
    check_eq("abort_quiet", 32'(hi), 32'd0);
    run_frame(32'hE718_FF00, 1'b0, -1);
    check_eq("post_len", 32'(n_busy), 32'd1210);
    check_eq("post_decode", decode_env(n_busy), 32'hE718_FF00);
    check_eq("post_done", done_at_fall, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
